// File: rtl/alu_exec_sequencer.sv
// -----------------------------------------------------------------------------
// alu_exec_sequencer
//
// Execution stage of the APB ALU, sitting between FIFO_IN and FIFO_OUT.
// While start_bit is set and FIFO_IN holds an entry, it pops one
// {op, data0, data1} entry. It executes that entry as a single-cycle add, an
// iterative shift-add multiply, or a flagged bad op. It then pushes one
// {op_err, result} word into FIFO_OUT. Only one operation is in flight at a
// time.
//
// Ports
//   clk        in   1               clock, rising edge
//   rst        in   1               synchronous reset, active-high
//   start_bit  in   1               enable; 0 blocks new pops from IDLE
//   empty_in   in   1               FIFO_IN empty
//   rdata_in   in   FIFO_IN_WIDTH   FIFO_IN data, valid the cycle after r_en_in
//   r_en_in    out  1               FIFO_IN pop strobe
//   full_out   in   1               FIFO_OUT full
//   w_en_out   out  1               FIFO_OUT push strobe
//   wdata_out  out  FIFO_OUT_WIDTH  FIFO_OUT write data {op_err, result}
//   busy       out  1               high whenever not IDLE
//   done_cnt   out  CNT_WIDTH       number of pushed words, wrapping
// -----------------------------------------------------------------------------
module alu_exec_sequencer #(
  parameter int DATA_WIDTH     = 12,
  parameter int OPERATION_SIZE = 2,
  parameter int FIFO_IN_WIDTH  = OPERATION_SIZE + 2*DATA_WIDTH,
  parameter int FIFO_OUT_WIDTH = 2*DATA_WIDTH + 1,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_bit,
  input  logic                      empty_in,
  input  logic [FIFO_IN_WIDTH-1:0]  rdata_in,
  output logic                      r_en_in,
  input  logic                      full_out,
  output logic                      w_en_out,
  output logic [FIFO_OUT_WIDTH-1:0] wdata_out,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      done_cnt
);

  localparam int RES_WIDTH = 2*DATA_WIDTH;
  localparam int BIT_CNT_W = 4;

  localparam logic [OPERATION_SIZE-1:0] OP_ADD = OPERATION_SIZE'(1);
  localparam logic [OPERATION_SIZE-1:0] OP_MUL = OPERATION_SIZE'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Operand and datapath registers
  logic [OPERATION_SIZE-1:0] op_reg;
  logic [DATA_WIDTH-1:0]     a_reg;
  logic [DATA_WIDTH-1:0]     b_reg;
  logic [RES_WIDTH-1:0]      acc_reg;
  logic [BIT_CNT_W-1:0]      bit_cnt_reg;
  logic [FIFO_OUT_WIDTH-1:0] word_reg;
  logic [CNT_WIDTH-1:0]      done_cnt_reg;

  logic                      is_mul;
  logic                      is_add;
  logic                      mul_last;
  logic [RES_WIDTH-1:0]      addend;
  logic [RES_WIDTH-1:0]      acc_sum;
  logic [RES_WIDTH-1:0]      add_sum;

  // Partial products, one per multiplier bit. The multiply walks these LSB
  // first, selecting one per EXEC cycle by bit_cnt_reg.
  logic [RES_WIDTH-1:0] pp [DATA_WIDTH];

  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_pp
      assign pp[gi] = b_reg[gi] ? ({{DATA_WIDTH{1'b0}}, a_reg} << gi) : '0;
    end
  endgenerate

  assign is_mul   = (op_reg == OP_MUL);
  assign is_add   = (op_reg == OP_ADD);
  assign mul_last = (bit_cnt_reg == BIT_CNT_W'(DATA_WIDTH - 1));
  assign addend   = pp[bit_cnt_reg];
  assign acc_sum  = acc_reg + addend;
  assign add_sum  = {{DATA_WIDTH{1'b0}}, a_reg} + {{DATA_WIDTH{1'b0}}, b_reg};

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and strobes. Both strobes are decoded from the state
  // register, and each lives in a different state. Pop and push therefore can
  // never coincide.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    r_en_in    = 1'b0;
    w_en_out   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_bit && !empty_in) begin
          r_en_in    = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        state_next = EXEC;
      end
      EXEC: begin
        // Add and bad ops finish in one cycle. Multiply stays until the last
        // multiplier bit has been accumulated.
        if (!is_mul || mul_last) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (!full_out) begin
          w_en_out   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      acc_reg      <= '0;
      bit_cnt_reg  <= '0;
      word_reg     <= '0;
      done_cnt_reg <= '0;
    end else begin
      case (state_reg)
        FETCH: begin
          // rdata_in is valid now, one cycle after the pop strobe.
          op_reg      <= rdata_in[FIFO_IN_WIDTH-1 -: OPERATION_SIZE];
          a_reg       <= rdata_in[2*DATA_WIDTH-1 -: DATA_WIDTH];
          b_reg       <= rdata_in[DATA_WIDTH-1:0];
          acc_reg     <= '0;
          bit_cnt_reg <= '0;
        end
        EXEC: begin
          if (is_mul) begin
            acc_reg     <= acc_sum;
            bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
            if (mul_last) begin
              word_reg <= {1'b0, acc_sum};
            end
          end else if (is_add) begin
            word_reg <= {1'b0, add_sum};
          end else begin
            // Unknown op codes give a zero result with the error flag set.
            // The word is still pushed, so a bad op never stalls the pipe.
            word_reg <= {1'b1, {RES_WIDTH{1'b0}}};
          end
        end
        default: begin
        end
      endcase

      if (w_en_out) begin
        done_cnt_reg <= done_cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  // word_reg only changes in EXEC, so it is stable for all of WRITE.
  assign wdata_out = word_reg;
  assign busy      = (state_reg != IDLE);
  assign done_cnt  = done_cnt_reg;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
module tb_alu_exec_sequencer;

  localparam int DW = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_bit;
  logic        empty_in;
  logic [25:0] rdata_in;
  logic        r_en_in;
  logic        full_out;
  logic        w_en_out;
  logic [24:0] wdata_out;
  logic        busy;
  logic [7:0]  done_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int exp_done = 0;

  alu_exec_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start_bit (start_bit),
    .empty_in  (empty_in),
    .rdata_in  (rdata_in),
    .r_en_in   (r_en_in),
    .full_out  (full_out),
    .w_en_out  (w_en_out),
    .wdata_out (wdata_out),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] a;
    logic [11:0] b;
    logic [24:0] word;
    int          lat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic on the operation's meaning.
  function automatic logic [24:0] ref_word(input logic [25:0] e);
    int unsigned a = e[23:12];
    int unsigned b = e[11:0];
    case (e[25:24])
      2'b01:   ref_word = {1'b0, 24'(a + b)};
      2'b10:   ref_word = {1'b0, 24'(a * b)};
      default: ref_word = 25'h1000000;
    endcase
  endfunction

  function automatic int ref_lat(input logic [25:0] e);
    ref_lat = (e[25:24] == 2'b10) ? (2 + DW) : 3;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start_bit = 1'b0; full_out = 1'b0; empty_in = 1'b1; rdata_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_done = 0;
  endtask

  // Offer one entry, wait for its pop, service the FIFO read, wait for the
  // push and check word, latency, strobe exclusivity and done_cnt.
  task automatic do_op(input logic [25:0] e, input logic [24:0] word, input int lat);
    int  t0;
    bit  got;
    bit  bad;
    start_bit = 1'b1;
    empty_in  = 1'b0;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (r_en_in) begin got = 1; break; end
      @(negedge clk);
    end
    check("pop_seen", 32'(got), 32'd1);
    if (!got) begin empty_in = 1'b1; return; end
    t0 = cyc;
    @(negedge clk);
    rdata_in = e;
    empty_in = 1'b1;
    got = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (r_en_in) bad = 1;
      if (w_en_out) begin got = 1; break; end
      @(negedge clk);
    end
    check("push_seen", 32'(got), 32'd1);
    if (!got) return;
    check("no_pop_in_flight", 32'(bad), 32'd0);
    check("latency", 32'(cyc - t0), 32'(lat));
    check("wdata", 32'(wdata_out), 32'(word));
    exp_done++;
    @(negedge clk);
    check("done_cnt", 32'(done_cnt), 32'(exp_done[7:0]));
    check("idle_after_push", 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2'b01, 12'hFFF, 12'h001, 25'h0001000, 3};
    vecs[1] = '{2'b10, 12'hFFF, 12'hFFF, 25'h0FFE001, 14};
    vecs[2] = '{2'b10, 12'h000, 12'hABC, 25'h0000000, 14};
    vecs[3] = '{2'b00, 12'h123, 12'h456, 25'h1000000, 3};
    vecs[4] = '{2'b01, 12'h123, 12'h456, 25'h0000579, 3};
    vecs[5] = '{2'b11, 12'hFFF, 12'hFFF, 25'h1000000, 3};
    vecs[6] = '{2'b10, 12'h001, 12'hABC, 25'h0000ABC, 14};
    vecs[7] = '{2'b01, 12'h800, 12'h800, 25'h0001000, 3};
    vecs[8] = '{2'b10, 12'h800, 12'h002, 25'h0001000, 14};
    vecs[9] = '{2'b01, 12'h000, 12'h000, 25'h0000000, 3};

    // Reset, then start_bit low with FIFO_IN non-empty: nothing happens.
    rst = 1'b1; start_bit = 1'b0; full_out = 1'b0; empty_in = 1'b0; rdata_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    begin
      bit moved = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (r_en_in || busy || w_en_out || done_cnt != 8'd0) moved = 1;
      end
      check("idle_no_start", 32'(moved), 32'd0);
      check("reset_wdata", 32'(wdata_out), 32'd0);
      check("reset_done_cnt", 32'(done_cnt), 32'd0);
    end
    empty_in = 1'b1;

    // Reset during multiply EXEC: abort, no push, count stays 0.
    begin
      int  t0;
      bit  got = 0;
      bit  pushed = 0;
      start_bit = 1'b1; empty_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
        #1;
        if (r_en_in) begin got = 1; break; end
        @(negedge clk);
      end
      check("rstmul_pop", 32'(got), 32'd1);
      t0 = cyc;
      @(negedge clk);
      rdata_in = {2'b10, 12'hFFF, 12'hFFF};
      empty_in = 1'b1;
      for (int i = 0; i < 20 && cyc < t0 + 6; i++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rstmul_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (w_en_out) pushed = 1;
      end
      check("rstmul_no_push", 32'(pushed), 32'd0);
      check("rstmul_done_cnt", 32'(done_cnt), 32'd0);
      exp_done = 0;
    end

    // Table-driven directed vectors, applied back to back.
    for (int i = 0; i < 10; i++)
      do_op({vecs[i].op, vecs[i].a, vecs[i].b}, vecs[i].word, vecs[i].lat);

    // FIFO_OUT full for 5 cycles in WRITE, with another entry waiting.
    begin
      int  t0;
      bit  got = 0;
      full_out = 1'b1; start_bit = 1'b1; empty_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
        #1;
        if (r_en_in) begin got = 1; break; end
        @(negedge clk);
      end
      check("stall_pop", 32'(got), 32'd1);
      t0 = cyc;
      @(negedge clk);
      rdata_in = {2'b01, 12'h00A, 12'h005};
      empty_in = 1'b1;
      for (int i = 0; i < 10 && cyc < t0 + 3; i++) @(negedge clk);
      empty_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
        #1;
        check("stall_w_en", 32'(w_en_out), 32'd0);
        check("stall_r_en", 32'(r_en_in), 32'd0);
        check("stall_wdata", 32'(wdata_out), 32'h000000F);
        @(negedge clk);
      end
      check("stall_busy", 32'(busy), 32'd1);
      full_out = 1'b0;
      #1;
      check("stall_release_push", 32'(w_en_out), 32'd1);
      check("stall_release_wdata", 32'(wdata_out), 32'h000000F);
      empty_in = 1'b1;
      exp_done++;
      @(negedge clk);
      check("stall_idle", 32'(busy), 32'd0);
      check("stall_done_cnt", 32'(done_cnt), 32'(exp_done[7:0]));
    end

    // Randomized operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [25:0] e;
      e = {2'($urandom_range(0, 3)), 12'($urandom), 12'($urandom)};
      do_op(e, ref_word(e), ref_lat(e));
    end

    // 256 pushes after a reset: done_cnt wraps to 0.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [25:0] e;
      e = {2'b01, 12'($urandom), 12'($urandom)};
      do_op(e, ref_word(e), ref_lat(e));
    end
    check("done_cnt_wrap", 32'(done_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
